vga_rect_address_gen: RTL and testbench

//  Walks a user rectangle (x0,y0,w,h) in row-major order, one pixel per valid/ready handshake.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_xy_to_addr.sv | 49 ++++
 rtl/vga_rect_address_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_rect_address_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the rectangle address generator:
//   - default screen geometry (160 x 120)
//   - width helpers used to size coordinate and address buses
//   - the walker state enum {IDLE, RUN, DONE}
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package vga_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Position of the highest set bit of n (n > 0).
    function automatic int floor_log2(input int n);
        int r;
        r = 0;
        while ((n >> (r + 1)) != 0) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/vga_xy_to_addr.sv
// ---------------------------------------------------------------------------
// vga_xy_to_addr
// Combinational linear address: addr_o = y_i * SCREEN_W + x_i (mod 2^ADDR_W).
// When SCREEN_W is one power of two or the sum of two, the product is built
// from shifts and adds; any other width falls back to a plain multiply.
// Only used once per rectangle, at capture time.
// Ports:
//   x_i     in  X_W     column
//   y_i     in  Y_W     row
//   addr_o  out ADDR_W  linear video-memory address
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_xy_to_addr
    import vga_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int X_W      = coord_w(SCREEN_W),
    parameter int Y_W      = coord_w(SCREEN_H_DEF),
    parameter int ADDR_W   = coord_w(SCREEN_W * SCREEN_H_DEF)
) (
    input  logic [X_W-1:0]    x_i,
    input  logic [Y_W-1:0]    y_i,
    output logic [ADDR_W-1:0] addr_o
);

    // Remainder after removing the top power of two from SCREEN_W.
    localparam int REST = SCREEN_W - (1 << floor_log2(SCREEN_W));

    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;

    assign x_ext = ADDR_W'(x_i);
    assign y_ext = ADDR_W'(y_i);

    generate
        if (REST == 0) begin : g_pow2
            assign addr_o = (y_ext << floor_log2(SCREEN_W)) + x_ext;
        end else if (is_pow2(REST)) begin : g_two_pow2
            // e.g. 160 = 128 + 32, 320 = 256 + 64
            assign addr_o = (y_ext << floor_log2(SCREEN_W))
                          + (y_ext << floor_log2(REST))
                          + x_ext;
        end else begin : g_mul
            assign addr_o = y_ext * ADDR_W'(SCREEN_W) + x_ext;
        end
    endgenerate

endmodule

// File: rtl/vga_rect_address_gen.sv
// ---------------------------------------------------------------------------
// vga_rect_address_gen
// Walks the rectangle (x0, y0, w, h) in row-major order, presenting one pixel
// per valid/ready handshake with its screen coordinates and linear address.
// The first address is formed once at capture; every later address is an
// increment (+1 along a row, +SCREEN_W from the saved row base at row end).
// Optional build macro: VGA_RECT_CLIP_EN clips the rectangle to the screen.
// Ports:
//   clock      in   1       rising-edge clock
//   resetn     in   1       synchronous active-low reset
//   start      in   1       capture request, honoured only in IDLE
//   x0, y0     in   X_W/Y_W rectangle origin
//   w, h       in   X_W+1/Y_W+1 rectangle size (0 allowed)
//   busy       out  1       high in RUN and DONE
//   out_valid  out  1       out_x/out_y/out_addr hold a pixel
//   out_ready  in   1       consumer accepts the pixel
//   out_x      out  X_W     pixel column
//   out_y      out  Y_W     pixel row
//   out_addr   out  ADDR_W  out_y*SCREEN_W + out_x
//   done       out  1       one-cycle pulse after the walk ends
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_rect_address_gen
    import vga_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int X_W      = coord_w(SCREEN_W),
    parameter int Y_W      = coord_w(SCREEN_H),
    parameter int ADDR_W   = coord_w(SCREEN_W * SCREEN_H)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    input  logic [X_W:0]      w,
    input  logic [Y_W:0]      h,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [X_W-1:0]    out_x,
    output logic [Y_W-1:0]    out_y,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done
);

    state_e            state_q,    state_d;
    logic [X_W-1:0]    x_q,        x_d;
    logic [Y_W-1:0]    y_q,        y_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [X_W-1:0]    x0_q,       x0_d;
    logic [X_W:0]      width_q,    width_d;
    logic [X_W:0]      col_left_q, col_left_d;
    logic [Y_W:0]      row_left_q, row_left_d;

    logic [X_W:0]      eff_w;
    logic [Y_W:0]      eff_h;
    logic [ADDR_W-1:0] start_addr;

    vga_xy_to_addr #(
        .SCREEN_W (SCREEN_W),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .ADDR_W   (ADDR_W)
    ) u_xy_to_addr (
        .x_i    (x0),
        .y_i    (y0),
        .addr_o (start_addr)
    );

`ifdef VGA_RECT_CLIP_EN
    logic [X_W:0] x_room;
    logic [Y_W:0] y_room;

    // An origin off the screen collapses to an empty rectangle; otherwise the
    // size is limited to the room left before the right/bottom edge.
    always_comb begin
        x_room = (X_W+1)'(SCREEN_W) - {1'b0, x0};
        y_room = (Y_W+1)'(SCREEN_H) - {1'b0, y0};
        eff_w  = '0;
        eff_h  = '0;
        if ({1'b0, x0} < (X_W+1)'(SCREEN_W)) eff_w = (w < x_room) ? w : x_room;
        if ({1'b0, y0} < (Y_W+1)'(SCREEN_H)) eff_h = (h < y_room) ? h : y_room;
    end
`else
    assign eff_w = w;
    assign eff_h = h;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            row_base_q <= '0;
            x0_q       <= '0;
            width_q    <= '0;
            col_left_q <= '0;
            row_left_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            x0_q       <= x0_d;
            width_q    <= width_d;
            col_left_q <= col_left_d;
            row_left_q <= row_left_d;
        end
    end

    // NOTE: every signal driven here gets a hold-value default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        x0_d       = x0_q;
        width_d    = width_q;
        col_left_d = col_left_q;
        row_left_d = row_left_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d       = x0;
                    width_d    = eff_w;
                    x_d        = x0;
                    y_d        = y0;
                    addr_d     = start_addr;
                    row_base_d = start_addr;
                    col_left_d = eff_w;
                    row_left_d = eff_h;
                    state_d    = (eff_w == '0 || eff_h == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (col_left_q == (X_W+1)'(1)) begin
                        if (row_left_q == (Y_W+1)'(1)) begin
                            state_d = DONE;
                        end else begin
                            // Next row restarts from the saved base, not from
                            // the current address, so no back-subtraction.
                            x_d        = x0_q;
                            y_d        = y_q + Y_W'(1);
                            addr_d     = row_base_q + ADDR_W'(SCREEN_W);
                            row_base_d = row_base_q + ADDR_W'(SCREEN_W);
                            col_left_d = width_q;
                            row_left_d = row_left_q - (Y_W+1)'(1);
                        end
                    end else begin
                        x_d        = x_q + X_W'(1);
                        addr_d     = addr_q + ADDR_W'(1);
                        col_left_d = col_left_q - (X_W+1)'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_addr  = addr_q;

endmodule

// File: tb/tb_vga_rect_address_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_rect_address_gen
// Self-checking bench for vga_rect_address_gen at 160 x 120. A reference
// model pushes every expected pixel of a rectangle to a queue at start; each
// DUT handshake pops one entry and compares x, y and address. Expectations
// follow the VGA_RECT_CLIP_EN build macro the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_rect_address_gen;

    localparam int SW  = 160;
    localparam int SH  = 120;
    localparam int XW  = 8;
    localparam int YW  = 7;
    localparam int AW  = 15;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [AW-1:0] addr;
    } pix_t;

    logic          clock = 1'b0;
    logic          resetn;
    logic          start;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW:0]   w;
    logic [YW:0]   h;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic [AW-1:0] out_addr;
    logic          done;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    vga_rect_address_gen dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .w         (w),
        .h         (h),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_addr  (out_addr),
        .done      (done)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: pushes the expected pixel sequence, returns its length.
    function automatic int push_model(input int rx0, input int ry0, input int rw, input int rh);
        int   ew;
        int   eh;
        int   xi;
        int   yi;
        int   ai;
        pix_t p;
`ifdef VGA_RECT_CLIP_EN
        ew = (rx0 >= SW) ? 0 : ((rw < SW - rx0) ? rw : SW - rx0);
        eh = (ry0 >= SH) ? 0 : ((rh < SH - ry0) ? rh : SH - ry0);
`else
        ew = rw;
        eh = rh;
`endif
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                xi     = rx0 + c;
                yi     = ry0 + r;
                ai     = yi * SW + xi;
                p.x    = xi[XW-1:0];
                p.y    = yi[YW-1:0];
                p.addr = ai[AW-1:0];
                exp_q.push_back(p);
            end
        end
        return ew * eh;
    endfunction

    // mode 0: always ready; 1: ready low 3 cycles on pixel index 1; 2: random.
    task automatic run_rect(input int rx0, input int ry0, input int rw, input int rh,
                            input int mode, input bit poke_start);
        int   npix;
        int   cyc;
        int   nstall;
        int   stall_cnt;
        int   popped;
        int   budget;
        bit   got_done;
        pix_t e;

        exp_q.delete();
        x0        = rx0[XW-1:0];
        y0        = ry0[YW-1:0];
        w         = rw[XW:0];
        h         = rh[YW:0];
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        npix      = push_model(rx0, ry0, rw, rh);
        budget    = npix * 4 + 50;
        cyc       = 1;
        nstall    = 0;
        stall_cnt = 0;
        popped    = 0;
        got_done  = 1'b0;

        while (cyc <= budget) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            // Attempt to restart mid-walk with a different rectangle.
            if (poke_start && cyc == 2) begin
                start = 1'b1;
                x0    = '0;
                y0    = '0;
                w     = 9'd1;
                h     = 8'd1;
            end
            if (poke_start && cyc == 3) start = 1'b0;

            case (mode)
                1:       out_ready = !(popped == 1 && stall_cnt < 3);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            if (mode == 1 && !out_ready) stall_cnt++;

            if (out_valid) begin
                if (!out_ready) begin
                    nstall++;
                    if (exp_q.size() > 0) check("hold_addr", 32'(out_addr), 32'(exp_q[0].addr));
                end else if (exp_q.size() == 0) begin
                    check("extra_pixel", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    check("pix_x",    32'(out_x),    32'(e.x));
                    check("pix_y",    32'(out_y),    32'(e.y));
                    check("pix_addr", 32'(out_addr), 32'(e.addr));
                end
            end
            tick();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;

        check("done_seen", 32'(got_done), 32'd1);
        if (got_done) begin
            check("done_cycle",  32'(cyc),          32'(npix + nstall + 1));
            check("done_valid",  32'(out_valid),    32'd0);
            check("done_busy",   32'(busy),         32'd1);
            check("pix_missing", 32'(exp_q.size()), 32'd0);
            tick();
            check("idle_busy",   32'(busy),         32'd0);
            check("done_pulse",  32'(done),         32'd0);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        x0        = '0;
        y0        = '0;
        w         = '0;
        h         = '0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset state.
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_x",     32'(out_x),     32'd0);
        check("rst_y",     32'(out_y),     32'd0);
        check("rst_addr",  32'(out_addr),  32'd0);
        resetn = 1'b1;
        tick();

        // Small rectangle, always ready: 325..327, 485..487, done at T+7.
        run_rect(5, 2, 3, 2, 0, 1'b0);
        // Same with a 3-cycle stall on the second pixel.
        run_rect(5, 2, 3, 2, 1, 1'b0);
        // Empty rectangle: done at T+1, no pixels.
        run_rect(10, 10, 0, 5, 0, 1'b0);
        // Bottom-right corner, clipped or wrapping depending on build.
        run_rect(158, 119, 5, 3, 0, 1'b0);

        // Reset in the middle of a full-screen walk.
        x0        = '0;
        y0        = '0;
        w         = 9'd160;
        h         = 8'd120;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_valid_pre", 32'(out_valid), 32'd1);
        resetn = 1'b0;
        tick();
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_done",  32'(done),      32'd0);
        check("mid_rst_x",     32'(out_x),     32'd0);
        check("mid_rst_y",     32'(out_y),     32'd0);
        check("mid_rst_addr",  32'(out_addr),  32'd0);
        resetn = 1'b1;
        tick();
        check("mid_rst_idle", 32'(busy), 32'd0);

        // Fresh start after reset, with a start pulse while busy.
        run_rect(3, 4, 20, 3, 0, 1'b1);
        // Immediately restart in the IDLE cycle following DONE.
        run_rect(0, 0, 160, 120, 0, 1'b0);

        // Random rectangles with random back-pressure.
        for (int i = 0; i < 15; i++) begin
            run_rect($urandom_range(0, 159), $urandom_range(0, 119),
                     $urandom_range(0, 40), $urandom_range(0, 4), 2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
